// File: rtl/fifo_drain_serializer_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package : fifo_drain_pkg                                                   |
// | Purpose : Shared types and widths for the FIFO drain serializer.           |
// |           drain_state_t - FSM encoding (IDLE, REQ, LOAD, SEND)             |
// |           BYTE_W        - width of one serialized byte                     |
// |           FIFO_W        - width of one word of the upstream FIFO           |
// | Config  : FIFO_DRAIN_PARITY_EN is not used here.                           |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
package fifo_drain_pkg;

  localparam int BYTE_W = 8;
  localparam int FIFO_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    LOAD = 2'd2,
    SEND = 2'd3
  } drain_state_t;

endpackage
`default_nettype wire

// File: rtl/fifo_drain_serializer_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Interface: fifo_drain_serializer_if                                        |
// | Purpose  : Bundles the FIFO read side and the byte-stream side of the      |
// |            drain serializer.                                               |
// | Signals  : EN          - block enable (gates new FIFO requests)            |
// |            fifoEMPTY   - FIFO empty flag                                   |
// |            fifoDataOut - FIFO read data, valid the cycle after fifoRD      |
// |            fifoRD      - FIFO read strobe                                  |
// |            byteOut     - serialized byte                                   |
// |            byteValid   - byteOut valid                                     |
// |            byteReady   - sink accepts byte                                 |
// |            byteLast    - final byte of the current word                    |
// |            busy        - serializer not idle                               |
// |            byteParity  - even parity of byteOut (FIFO_DRAIN_PARITY_EN)     |
// | Modports : master - the serializer; slave - its environment.               |
// | Config   : FIFO_DRAIN_PARITY_EN adds byteParity.                           |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
interface fifo_drain_serializer_if
  import fifo_drain_pkg::*;
#(
  parameter int BYTES_PER_WORD = FIFO_W / BYTE_W
) ();

  localparam int WORD_W = BYTE_W * BYTES_PER_WORD;

  logic              EN;
  logic              fifoEMPTY;
  logic [WORD_W-1:0] fifoDataOut;
  logic              fifoRD;
  logic [BYTE_W-1:0] byteOut;
  logic              byteValid;
  logic              byteReady;
  logic              byteLast;
  logic              busy;
`ifdef FIFO_DRAIN_PARITY_EN
  logic              byteParity;
`endif

  modport master (
    input  EN, fifoEMPTY, fifoDataOut, byteReady,
`ifdef FIFO_DRAIN_PARITY_EN
    output byteParity,
`endif
    output fifoRD, byteOut, byteValid, byteLast, busy
  );

  modport slave (
    output EN, fifoEMPTY, fifoDataOut, byteReady,
`ifdef FIFO_DRAIN_PARITY_EN
    input  byteParity,
`endif
    input  fifoRD, byteOut, byteValid, byteLast, busy
  );

endinterface
`default_nettype wire

// File: rtl/fifo_drain_serializer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : fifo_drain_serializer                                            |
// | Purpose : Pops words from a FIFO read port (RD/EMPTY) and serializes each  |
// |           word into a valid/ready byte stream.                             |
// | Ports   : Clk   - clock, all logic on posedge                              |
// |           Rst_n - asynchronous active-low reset                            |
// |           bus   - fifo_drain_serializer_if.master (FIFO + byte stream)     |
// | Params  : BYTES_PER_WORD - bytes per FIFO word                             |
// |           MSB_FIRST      - 1: most significant byte first, 0: LSB first    |
// | Config  : FIFO_DRAIN_PARITY_EN adds bus.byteParity = ^byteOut (registered).|
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module fifo_drain_serializer
  import fifo_drain_pkg::*;
#(
  parameter int BYTES_PER_WORD = 4,
  parameter bit MSB_FIRST      = 1'b1
) (
  input  logic                    Clk,
  input  logic                    Rst_n,
  fifo_drain_serializer_if.master bus
);

  localparam int WORD_W = BYTE_W * BYTES_PER_WORD;
  localparam int IDX_W  = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES_PER_WORD - 1);

  drain_state_t      state_d, state_q;
  logic              fifo_rd_d, fifo_rd_q;
  logic [BYTE_W-1:0] byte_out_d, byte_out_q;
  logic              byte_valid_d, byte_valid_q;
  logic              byte_last_d, byte_last_q;
  logic              busy_d, busy_q;
  logic [WORD_W-1:0] word_d, word_q;
  logic [IDX_W-1:0]  idx_d, idx_q;
`ifdef FIFO_DRAIN_PARITY_EN
  logic              parity_d, parity_q;
`endif

  // Transmit order index i maps to a byte lane of the word.
  function automatic logic [BYTE_W-1:0] pick_byte(input logic [WORD_W-1:0] w,
                                                  input logic [IDX_W-1:0]  i);
    logic [IDX_W-1:0] lane;
    lane = MSB_FIRST ? (LAST_IDX - i) : i;
    return w[int'(lane)*BYTE_W +: BYTE_W];
  endfunction

  always_comb begin
    state_d      = state_q;
    fifo_rd_d    = 1'b0;
    byte_out_d   = byte_out_q;
    byte_valid_d = byte_valid_q;
    byte_last_d  = byte_last_q;
    word_d       = word_q;
    idx_d        = idx_q;

    case (state_q)
      IDLE: begin
        if (bus.EN && !bus.fifoEMPTY) begin
          state_d   = REQ;
          fifo_rd_d = 1'b1;
        end
      end
      REQ: begin
        state_d = LOAD;
      end
      LOAD: begin
        // FIFO data is valid now; first byte goes out straight from it so
        // byteValid rises on the very next cycle.
        word_d       = bus.fifoDataOut;
        idx_d        = '0;
        byte_out_d   = pick_byte(bus.fifoDataOut, '0);
        byte_valid_d = 1'b1;
        byte_last_d  = (LAST_IDX == '0);
        state_d      = SEND;
      end
      SEND: begin
        // Without byteReady everything holds, giving stable backpressure.
        if (bus.byteReady) begin
          if (idx_q == LAST_IDX) begin
            byte_valid_d = 1'b0;
            byte_last_d  = 1'b0;
            // Chain straight into the next request to reach peak rate.
            if (bus.EN && !bus.fifoEMPTY) begin
              state_d   = REQ;
              fifo_rd_d = 1'b1;
            end else begin
              state_d = IDLE;
            end
          end else begin
            idx_d       = idx_q + 1'b1;
            byte_out_d  = pick_byte(word_q, idx_q + 1'b1);
            byte_last_d = ((idx_q + 1'b1) == LAST_IDX);
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

`ifdef FIFO_DRAIN_PARITY_EN
  assign parity_d = ^byte_out_d;
`endif

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q      <= IDLE;
      fifo_rd_q    <= 1'b0;
      byte_out_q   <= '0;
      byte_valid_q <= 1'b0;
      byte_last_q  <= 1'b0;
      busy_q       <= 1'b0;
      word_q       <= '0;
      idx_q        <= '0;
`ifdef FIFO_DRAIN_PARITY_EN
      parity_q     <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      fifo_rd_q    <= fifo_rd_d;
      byte_out_q   <= byte_out_d;
      byte_valid_q <= byte_valid_d;
      byte_last_q  <= byte_last_d;
      busy_q       <= busy_d;
      word_q       <= word_d;
      idx_q        <= idx_d;
`ifdef FIFO_DRAIN_PARITY_EN
      parity_q     <= parity_d;
`endif
    end
  end

  assign bus.fifoRD    = fifo_rd_q;
  assign bus.byteOut   = byte_out_q;
  assign bus.byteValid = byte_valid_q;
  assign bus.byteLast  = byte_last_q;
  assign bus.busy      = busy_q;
`ifdef FIFO_DRAIN_PARITY_EN
  assign bus.byteParity = parity_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fifo_drain_serializer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_fifo_drain_serializer                                         |
// | Purpose : Directed self-checking bench for fifo_drain_serializer with a    |
// |           small FIFO model and a byte-stream sink.                         |
// | Config  : FIFO_DRAIN_PARITY_EN enables the byteParity checks.              |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module tb_fifo_drain_serializer;

  logic Clk = 1'b0;
  logic Rst_n;
  always #5 Clk = ~Clk;

  fifo_drain_serializer_if #(.BYTES_PER_WORD(4)) bus ();

  fifo_drain_serializer #(
    .BYTES_PER_WORD(4),
    .MSB_FIRST     (1'b1)
  ) dut (
    .Clk  (Clk),
    .Rst_n(Rst_n),
    .bus  (bus)
  );

  int n_compared   = 0;
  int n_mismatched = 0;

  logic [31:0] fifo_q[$];
  logic [7:0]  rx_byte[$];
  bit          rx_last[$];
  int          rx_cyc[$];
  int          rd_cyc[$];
`ifdef FIFO_DRAIN_PARITY_EN
  bit          rx_par[$];
`endif
  int          cyc;
  int          underflows;
  int          stall_left;
  int          stall_at;
  logic [7:0]  stall_exp;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] rxb(input int i);
    if (i < rx_byte.size()) return {24'h0, rx_byte[i]};
    return 32'hFFFF_FFFF;
  endfunction

  function automatic logic [31:0] rxl(input int i);
    if (i < rx_last.size()) return {31'h0, rx_last[i]};
    return 32'hFFFF_FFFF;
  endfunction

  function automatic int rxc(input int i);
    if (i < rx_cyc.size()) return rx_cyc[i];
    return -100;
  endfunction

  function automatic int rdc(input int i);
    if (i < rd_cyc.size()) return rd_cyc[i];
    return -1000;
  endfunction

  task automatic push_word(input logic [31:0] w);
    fifo_q.push_back(w);
    bus.fifoEMPTY = 1'b0;
  endtask

  task automatic clear_log();
    rx_byte.delete();
    rx_last.delete();
    rx_cyc.delete();
    rd_cyc.delete();
`ifdef FIFO_DRAIN_PARITY_EN
    rx_par.delete();
`endif
  endtask

  // One clock cycle: decide byteReady, sample pre-edge outputs, advance the
  // edge, then log transfers and service the FIFO model.
  task automatic tick();
    logic       v, r, l, rd, e;
    logic [7:0] b;
`ifdef FIFO_DRAIN_PARITY_EN
    logic       p;
`endif
    bus.byteReady = 1'b1;
    if (stall_left > 0 && bus.byteValid && rx_byte.size() == stall_at) begin
      bus.byteReady = 1'b0;
      stall_left--;
      check_eq("bp_hold_byte", {24'h0, bus.byteOut}, {24'h0, stall_exp});
    end
    v  = bus.byteValid;
    r  = bus.byteReady;
    b  = bus.byteOut;
    l  = bus.byteLast;
    rd = bus.fifoRD;
    e  = bus.fifoEMPTY;
`ifdef FIFO_DRAIN_PARITY_EN
    p  = bus.byteParity;
`endif
    @(posedge Clk);
    #1;
    if (v && r) begin
      rx_byte.push_back(b);
      rx_last.push_back(l);
      rx_cyc.push_back(cyc);
`ifdef FIFO_DRAIN_PARITY_EN
      rx_par.push_back(p);
`endif
    end
    if (rd) begin
      rd_cyc.push_back(cyc);
      if (e) underflows++;
      else   bus.fifoDataOut = fifo_q.pop_front();
    end
    bus.fifoEMPTY = (fifo_q.size() == 0);
    cyc++;
  endtask

  task automatic run_bytes(input string tag, input int n, input int budget);
    int k;
    k = 0;
    while (rx_byte.size() < n && k < budget) begin
      tick();
      k++;
    end
    check_eq({tag, "_byte_count"}, rx_byte.size(), n);
  endtask

  // Expected stream: each word MSB first, byteLast on the 4th byte only.
  task automatic verify_stream(input string tag, input logic [31:0] words[$]);
    for (int i = 0; i < words.size(); i++) begin
      for (int j = 0; j < 4; j++) begin
        check_eq($sformatf("%s_byte%0d", tag, 4*i+j), rxb(4*i+j),
                 (words[i] >> (8*(3-j))) & 32'hFF);
        check_eq($sformatf("%s_last%0d", tag, 4*i+j), rxl(4*i+j), (j == 3) ? 32'd1 : 32'd0);
      end
    end
  endtask

  initial begin
    logic [31:0] words[$];
    int k;

    Rst_n           = 1'b0;
    bus.EN          = 1'b1;
    bus.byteReady   = 1'b1;
    bus.fifoEMPTY   = 1'b1;
    bus.fifoDataOut = '0;
    cyc             = 0;
    underflows      = 0;
    stall_left      = 0;
    stall_at        = 0;
    stall_exp       = 8'h00;
    #1;

    // Test 1: reset held with a non-empty FIFO.
    push_word(32'hA1B2C3D4);
    for (int c = 0; c < 3; c++) begin
      tick();
      check_eq("rst_fifoRD",    bus.fifoRD,    0);
      check_eq("rst_byteValid", bus.byteValid, 0);
      check_eq("rst_byteOut",   bus.byteOut,   0);
      check_eq("rst_busy",      bus.busy,      0);
      check_eq("rst_byteLast",  bus.byteLast,  0);
    end
    check_eq("rst_no_rd", rd_cyc.size(), 0);

    // Test 2: single word, sink always ready.
    Rst_n = 1'b1;
    clear_log();
    run_bytes("t2", 4, 20);
    tick();
    tick();
    words = '{32'hA1B2C3D4};
    verify_stream("t2", words);
    check_eq("t2_rd_pulses",  rd_cyc.size(), 1);
    check_eq("t2_latency",    rxc(0), rdc(0) + 2);
    check_eq("t2_consec1",    rxc(1), rxc(0) + 1);
    check_eq("t2_consec3",    rxc(3), rxc(0) + 3);
    check_eq("t2_idle_busy",  bus.busy, 0);
    check_eq("t2_idle_valid", bus.byteValid, 0);

    // Test 3: backpressure for 3 cycles while B2 is presented.
    clear_log();
    stall_left = 3;
    stall_at   = 1;
    stall_exp  = 8'hB2;
    push_word(32'hA1B2C3D4);
    run_bytes("t3", 4, 30);
    tick();
    verify_stream("t3", words);
    check_eq("t3_stalls_used", stall_left, 0);
    check_eq("t3_rd_pulses",   rd_cyc.size(), 1);
    check_eq("t3_b2_stretch",  rxc(1) - rxc(0), 4);

    // Test 4: three queued words, peak-rate drain.
    clear_log();
    push_word(32'h11223344);
    push_word(32'h55667788);
    push_word(32'h99AABBCC);
    run_bytes("t4", 12, 60);
    repeat (4) tick();
    words = '{32'h11223344, 32'h55667788, 32'h99AABBCC};
    verify_stream("t4", words);
    check_eq("t4_rd_pulses", rd_cyc.size(), 3);
    check_eq("t4_underflow", underflows, 0);
    check_eq("t4_rd_period", rdc(1) - rdc(0), 6);
    check_eq("t4_word_rate", rxc(4) - rxc(0), 6);
    check_eq("t4_extra_rx",  rx_byte.size(), 12);

    // Test 5: EN dropped during the first byte of word 1.
    clear_log();
    push_word(32'h01020304);
    push_word(32'h05060708);
    k = 0;
    while (!bus.byteValid && k < 10) begin
      tick();
      k++;
    end
    check_eq("t5_sync_valid", bus.byteValid, 1);
    bus.EN = 1'b0;
    run_bytes("t5a", 4, 20);
    repeat (6) tick();
    check_eq("t5_hold_rd",    rd_cyc.size(), 1);
    check_eq("t5_hold_bytes", rx_byte.size(), 4);
    check_eq("t5_hold_busy",  bus.busy, 0);
    bus.EN = 1'b1;
    run_bytes("t5b", 8, 30);
    words = '{32'h01020304, 32'h05060708};
    verify_stream("t5", words);
    check_eq("t5_rd_pulses", rd_cyc.size(), 2);

    // Test 6: reset in the middle of SEND; the queued word follows intact.
    clear_log();
    push_word(32'hDEADBEEF);
    push_word(32'h07030102);
    k = 0;
    while (rx_byte.size() < 1 && k < 20) begin
      tick();
      k++;
    end
    check_eq("t6_in_send", bus.byteValid, 1);
    Rst_n = 1'b0;
    #1;
    check_eq("t6_rst_valid",  bus.byteValid, 0);
    check_eq("t6_rst_busy",   bus.busy,      0);
    check_eq("t6_rst_rd",     bus.fifoRD,    0);
    check_eq("t6_rst_byte",   bus.byteOut,   0);
    check_eq("t6_rst_last",   bus.byteLast,  0);
`ifdef FIFO_DRAIN_PARITY_EN
    check_eq("t6_rst_parity", bus.byteParity, 0);
`endif
    tick();
    tick();
    Rst_n = 1'b1;
    clear_log();
    run_bytes("t6", 4, 30);
    words = '{32'h07030102};
    verify_stream("t6", words);
    check_eq("t6_rd_pulses", rd_cyc.size(), 1);
`ifdef FIFO_DRAIN_PARITY_EN
    check_eq("t6_parity_07", (rx_par.size() > 0) ? {31'h0, rx_par[0]} : 32'hFF, 1);
    check_eq("t6_parity_03", (rx_par.size() > 1) ? {31'h0, rx_par[1]} : 32'hFF, 0);
    check_eq("t6_parity_01", (rx_par.size() > 2) ? {31'h0, rx_par[2]} : 32'hFF, 1);
`endif
    check_eq("final_underflow", underflows, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
`default_nettype wire
